uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares one `uart_tx` instance among `NUM_REQ` byte producers. It sits between the producer blocks and `uart_tx`. It latches one requester's byte, pulses the transmitter trigger, and tracks the transmitter's busy/done handshake. It reports per-requester grant and completion, so producers never drive `uart_tx` directly.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_tx_arbiter_rr_pick.sv | 43 ++++
 rtl/uart_tx_arbiter.sv | 147 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and helpers for the UART transmit-side blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int DEFAULT_PAYLOAD_BITS = 8;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_TRIG      = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } arb_state_t;

    // Width needed to hold 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin pick: first set request at or after
//               the pointer, searching cyclically.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = cnt_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_valid
);

    logic [IDX_W:0]   w_sum;
    logic [IDX_W-1:0] w_pos;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_sum   = '0;
        w_pos   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_sum = {1'b0, i_ptr} + (IDX_W+1)'(i);
            w_pos = (w_sum >= (IDX_W+1)'(NUM_REQ)) ?
                    IDX_W'(w_sum - (IDX_W+1)'(NUM_REQ)) : IDX_W'(w_sum);
            if (!o_valid && i_req[w_pos]) begin
                o_valid        = 1'b1;
                o_idx          = w_pos;
                o_grant[w_pos] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Round-robin sharing of one uart_tx among NUM_REQ producers.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int PAYLOAD_BITS = DEFAULT_PAYLOAD_BITS,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              i_req,
    input  logic [NUM_REQ*PAYLOAD_BITS-1:0] i_req_data,
    output logic [NUM_REQ-1:0]              o_grant,
    output logic [NUM_REQ-1:0]              o_done,
    output logic [NUM_REQ-1:0]              o_err,
    output logic                            o_busy,
    output logic                            o_tx_trig,
    output logic [PAYLOAD_BITS-1:0]         o_tx_data,
    input  logic                            i_tx_busy,
    input  logic                            i_tx_done
);

    localparam int               c_idx_w    = cnt_width(NUM_REQ);
    localparam int               c_cnt_w    = cnt_width(BUSY_TIMEOUT);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(BUSY_TIMEOUT - 1);
    localparam logic [c_idx_w-1:0] c_id_last  = c_idx_w'(NUM_REQ - 1);

    arb_state_t                r_state, w_state_next;
    logic [c_idx_w-1:0]        r_cur_id, w_cur_id_next;
    logic [c_idx_w-1:0]        r_rr_ptr, w_rr_ptr_next;
    logic [c_cnt_w-1:0]        r_cnt, w_cnt_next;
    logic [PAYLOAD_BITS-1:0]   r_data, w_data_next;
    logic [NUM_REQ-1:0]        r_done, w_done_next;
    logic [NUM_REQ-1:0]        r_err, w_err_next;
    logic                      r_cool, w_cool_next;

    logic [NUM_REQ-1:0]        w_pick_grant;
    logic [c_idx_w-1:0]        w_pick_idx;
    logic                      w_pick_valid;
    logic [PAYLOAD_BITS-1:0]   w_slice [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
        assign w_slice[g] = i_req_data[g*PAYLOAD_BITS +: PAYLOAD_BITS];
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (c_idx_w)
    ) u_pick (
        .i_req   (i_req),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_pick_grant),
        .o_idx   (w_pick_idx),
        .o_valid (w_pick_valid)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_cur_id <= '0;
            r_rr_ptr <= '0;
            r_cnt    <= '0;
            r_data   <= '0;
            r_done   <= '0;
            r_err    <= '0;
            r_cool   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_cur_id <= w_cur_id_next;
            r_rr_ptr <= w_rr_ptr_next;
            r_cnt    <= w_cnt_next;
            r_data   <= w_data_next;
            r_done   <= w_done_next;
            r_err    <= w_err_next;
            r_cool   <= w_cool_next;
        end
    end

    // r_cool marks the completion-pulse cycle: no new grant until the next one.
    always_comb begin
        w_state_next  = r_state;
        w_cur_id_next = r_cur_id;
        w_rr_ptr_next = r_rr_ptr;
        w_cnt_next    = r_cnt;
        w_data_next   = r_data;
        w_done_next   = '0;
        w_err_next    = '0;
        w_cool_next   = 1'b0;
        o_grant       = '0;
        o_tx_trig     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_pick_valid && !r_cool && !reset) begin
                    o_grant       = w_pick_grant;
                    w_cur_id_next = w_pick_idx;
                    w_data_next   = w_slice[w_pick_idx];
                    w_state_next  = ST_TRIG;
                end
            end
            ST_TRIG: begin
                o_tx_trig    = 1'b1;
                w_cnt_next   = '0;
                w_state_next = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (i_tx_done) begin
                    w_done_next[r_cur_id] = 1'b1;
                    w_state_next          = ST_IDLE;
                end else if (i_tx_busy) begin
                    w_state_next = ST_WAIT_DONE;
                end else if (r_cnt == c_cnt_last) begin
                    w_err_next[r_cur_id] = 1'b1;
                    w_state_next         = ST_IDLE;
                end else begin
                    w_cnt_next = r_cnt + c_cnt_w'(1);
                end
            end
            ST_WAIT_DONE: begin
                if (i_tx_done) begin
                    w_done_next[r_cur_id] = 1'b1;
                    w_state_next          = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        if ((r_state != ST_IDLE) && (w_state_next == ST_IDLE)) begin
            w_cool_next   = 1'b1;
            w_rr_ptr_next = (r_cur_id == c_id_last) ? '0 : r_cur_id + c_idx_w'(1);
        end
    end

    assign o_busy    = (r_state != ST_IDLE) || (|o_grant);
    assign o_tx_data = r_data;
    assign o_done    = r_done;
    assign o_err     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Self-checking bench for uart_tx_arbiter with a uart_tx stub.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int N     = 4;
    localparam int PB    = 8;
    localparam int T     = 16;
    localparam int FRAME = 12;

    logic            clk      = 1'b0;
    logic            reset    = 1'b1;
    logic [N-1:0]    req      = '0;
    logic [N*PB-1:0] req_data = '0;
    logic [N-1:0]    grant, done, err;
    logic            busy, trig;
    logic [PB-1:0]   tx_data;
    logic            tx_busy  = 1'b0;
    logic            tx_done  = 1'b0;

    int checks = 0, failures = 0, cyc = 0;
    int stub_mode = 0;     // 0 normal frame, 1 never busy, 2 instant done
    int stub_cnt  = 0;

    int grant_ids[$], grant_cyc[$], done_ids[$], done_cyc[$];
    int err_ids[$], err_cyc[$], trig_cyc[$];

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ      (N),
        .PAYLOAD_BITS (PB),
        .BUSY_TIMEOUT (T)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .i_req      (req),
        .i_req_data (req_data),
        .o_grant    (grant),
        .o_done     (done),
        .o_err      (err),
        .o_busy     (busy),
        .o_tx_trig  (trig),
        .o_tx_data  (tx_data),
        .i_tx_busy  (tx_busy),
        .i_tx_done  (tx_done)
    );

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
            stub_cnt <= 0;
        end else begin
            tx_done <= 1'b0;
            if (tx_busy) begin
                if (stub_cnt == 0) begin
                    tx_busy <= 1'b0;
                    tx_done <= 1'b1;
                end else begin
                    stub_cnt <= stub_cnt - 1;
                end
            end else if (trig) begin
                if (stub_mode == 0) begin
                    tx_busy  <= 1'b1;
                    stub_cnt <= FRAME - 1;
                end else if (stub_mode == 2) begin
                    tx_done <= 1'b1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int i = 0; i < N; i++)
            if (r[(p + i) % N]) return (p + i) % N;
        return -1;
    endfunction

    function automatic int ohid(input logic [N-1:0] v);
        for (int i = 0; i < N; i++)
            if (v[i]) return i;
        return -1;
    endfunction

    // Reference model: frame timeline in cycle numbers relative to the grant.
    int            m_ptr = 0, m_id = 0, m_tg = 0;
    int            p_kind = 0, p_id = 0, p_cyc = -1;
    bit            m_act = 1'b0, m_busy_seen = 1'b0;
    logic [PB-1:0] m_data = '0;

    always @(negedge clk) begin
        logic [N-1:0] eg, ed, ee;
        bit           cool;
        int           pid;
        cyc++;
        if (reset) begin
            check("rst_grant", grant, 0);
            check("rst_done", done, 0);
            check("rst_err", err, 0);
            check("rst_busy", busy, 0);
            check("rst_trig", trig, 0);
            check("rst_data", tx_data, 0);
            m_act = 1'b0;
            m_ptr = 0;
            p_cyc = -1;
        end else begin
            ed   = '0;
            ee   = '0;
            eg   = '0;
            pid  = -1;
            cool = (p_cyc == cyc);
            if (cool && p_kind == 1) ed[p_id] = 1'b1;
            if (cool && p_kind == 2) ee[p_id] = 1'b1;
            if (!m_act && !cool) pid = pick(req, m_ptr);
            if (pid >= 0) eg[pid] = 1'b1;

            check("grant", grant, eg);
            check("done", done, ed);
            check("err", err, ee);
            check("trig", trig, (m_act && cyc == m_tg + 1));
            check("busy", busy, (m_act || pid >= 0));
            if (m_act && cyc > m_tg) check("tx_data", tx_data, m_data);

            if (grant != 0) begin grant_ids.push_back(ohid(grant)); grant_cyc.push_back(cyc); end
            if (done != 0)  begin done_ids.push_back(ohid(done));   done_cyc.push_back(cyc);  end
            if (err != 0)   begin err_ids.push_back(ohid(err));     err_cyc.push_back(cyc);   end
            if (trig)       trig_cyc.push_back(cyc);

            if (pid >= 0) begin
                m_act       = 1'b1;
                m_id        = pid;
                m_tg        = cyc;
                m_data      = req_data[pid*PB +: PB];
                m_busy_seen = 1'b0;
            end else if (m_act && cyc >= m_tg + 2) begin
                if (tx_done || (!m_busy_seen && !tx_busy && cyc == m_tg + T + 1)) begin
                    p_kind = tx_done ? 1 : 2;
                    p_id   = m_id;
                    p_cyc  = cyc + 1;
                    m_act  = 1'b0;
                    m_ptr  = (m_id + 1) % N;
                end else if (tx_busy) begin
                    m_busy_seen = 1'b1;
                end
            end
        end
    end

    // which: 0 = grants seen, 1 = frames ended (done + err)
    task automatic wait_count(input int which, input int target, input int budget);
        int n = 0;
        while (((which == 0) ? grant_ids.size() : done_ids.size() + err_ids.size()) < target
               && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (n >= budget) begin
            checks++;
            failures++;
            $display("FAIL wait_timeout: kind %0d reached no target %0d within %0d cycles", which, target, budget);
        end
        #1;
    endtask

    initial begin
        #1;
        check("lit_rst_busy", busy, 0);
        check("lit_rst_grant", grant, 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // all four requesting continuously
        req_data = {8'h44, 8'h33, 8'h22, 8'h11};
        req      = 4'b1111;
        wait_count(0, 5, 500);
        req = 4'b0000;
        wait_count(1, 5, 500);
        for (int i = 0; i < 5; i++) begin
            check("lit_rr_grant_order", grant_ids[i], i % 4);
            check("lit_rr_done_order", done_ids[i], i % 4);
        end
        check("lit_frame_len", done_cyc[0] - grant_cyc[0], 15);
        check("lit_trig_lat", trig_cyc[0] - grant_cyc[0], 1);
        check("lit_gap", grant_cyc[1] - done_cyc[0], 1);

        // single request from requester 1
        req_data[15:8] = 8'h55;
        req            = 4'b0010;
        wait_count(0, 6, 200);
        check("lit_single_grant", grant_ids[5], 1);
        check("lit_single_data", tx_data, 8'h55);
        req = 4'b0000;
        wait_count(1, 6, 200);
        check("lit_single_done", done_ids[5], 1);

        // fairness after wrap: pointer moves to 3, then 3 beats 0
        req = 4'b0100;
        wait_count(0, 7, 200);
        req = 4'b0000;
        wait_count(1, 7, 200);
        req = 4'b1001;
        wait_count(0, 8, 200);
        check("lit_fair_first", grant_ids[7], 3);
        req = 4'b0001;
        wait_count(0, 9, 200);
        check("lit_fair_second", grant_ids[8], 0);
        req = 4'b0000;
        wait_count(1, 9, 200);

        // busy timeout with a transmitter that never answers
        stub_mode      = 1;
        req_data[15:8] = 8'h5A;
        req            = 4'b0010;
        wait_count(0, 10, 200);
        req = 4'b0000;
        wait_count(1, 10, 200);
        check("lit_err_id", err_ids[0], 1);
        check("lit_err_delay", err_cyc[0] - trig_cyc[9], T + 1);
        check("lit_err_no_done", done_ids.size(), 9);
        stub_mode = 0;
        req       = 4'b0100;
        wait_count(0, 11, 200);
        req = 4'b0000;
        wait_count(1, 11, 200);
        check("lit_after_err_done", done_ids[9], 2);

        // fast transmitter: done without busy
        stub_mode = 2;
        req       = 4'b1000;
        wait_count(0, 12, 200);
        req = 4'b0000;
        wait_count(1, 12, 200);
        check("lit_fast_done", done_ids[10], 3);
        check("lit_fast_delay", done_cyc[10] - trig_cyc[11], 2);
        check("lit_fast_no_err", err_ids.size(), 1);
        stub_mode = 0;

        // reset in the middle of the 0x99 frame
        req_data[15:8] = 8'h99;
        req            = 4'b0010;
        wait_count(0, 13, 200);
        req = 4'b0011;
        repeat (6) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("lit_async_busy", busy, 0);
        check("lit_async_data", tx_data, 0);
        check("lit_async_trig", trig, 0);
        check("lit_async_grant", grant, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        wait_count(0, 14, 200);
        check("lit_post_rst_grant", grant_ids[13], 0);
        req = 4'b0000;
        wait_count(1, 13, 200);
        check("lit_post_rst_done", done_ids[11], 0);
        check("lit_post_rst_count", done_ids.size() + err_ids.size(), 13);

        repeat (4) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
